// File: rtl/ais_frame_gate.sv
// ============================================================================
// ais_frame_gate
// ----------------------------------------------------------------------------
// Turns the AIS frame detector's aligned IQ stream into fixed-length,
// delimited AXI-Stream packets. Up to PAR_CHANNELS channels share one
// time-multiplexed stream tagged by tid. Each channel has its own
// IDLE / ACTIVE / HOLDOFF state and beat counter. A start-of-frame (tuser)
// that arrives while a frame is open is either dropped and counted, or it
// restarts the frame (PAR_RETRIGGER=1).
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   s_axis_*           input beat: tvalid, tdata {Q,I}, tuser = start-of-frame,
//                      tid = channel index, tready (0 while in reset)
//   m_axis_*           registered output beat, 1 clock latency, no backpressure;
//                      tuser = first sample of a frame, tlast = last sample
//   o_trunc            pulse with m_axis_tvalid when a restart cuts a frame short
//   o_busy             per channel: 1 while ACTIVE or HOLDOFF
//   o_drop_cnt         saturating count of ignored start-of-frame flags
// ============================================================================
module ais_frame_gate #(
    parameter int PAR_DATA_WIDTH = 16,
    parameter int PAR_CHANNELS   = 2,
    parameter int PAR_FRAME_LEN  = 2112,
    parameter int PAR_HOLDOFF    = 64,
    parameter int PAR_RETRIGGER  = 0,
    localparam int K_CH_WIDTH    = (PAR_CHANNELS > 1) ? $clog2(PAR_CHANNELS) : 1,
    localparam int K_CNT_WIDTH   =
        $clog2(((PAR_FRAME_LEN > PAR_HOLDOFF) ? PAR_FRAME_LEN : PAR_HOLDOFF) + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        s_axis_tvalid,
    input  logic [2*PAR_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tuser,
    input  logic [K_CH_WIDTH-1:0]       s_axis_tid,
    output logic                        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [2*PAR_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic [K_CH_WIDTH-1:0]       m_axis_tid,
    output logic                        o_trunc,
    output logic [PAR_CHANNELS-1:0]     o_busy,
    output logic [15:0]                 o_drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Counter value seen on the final beat of a frame / of a holdoff period.
    localparam logic [K_CNT_WIDTH-1:0] K_LAST_CNT = K_CNT_WIDTH'(PAR_FRAME_LEN - 1);
    localparam logic [K_CNT_WIDTH-1:0] K_HOLD_END = K_CNT_WIDTH'(PAR_HOLDOFF - 1);
    localparam logic [K_CNT_WIDTH-1:0] K_ONE      = K_CNT_WIDTH'(1);
    localparam logic [K_CH_WIDTH:0]    K_CH_LIMIT = (K_CH_WIDTH + 1)'(PAR_CHANNELS);

    state_t                 state_q [PAR_CHANNELS];
    state_t                 state_d [PAR_CHANNELS];
    logic [K_CNT_WIDTH-1:0] cnt_q   [PAR_CHANNELS];
    logic [K_CNT_WIDTH-1:0] cnt_d   [PAR_CHANNELS];

    state_t                 cur_state;
    logic [K_CNT_WIDTH-1:0] cur_cnt;
    logic                   beat_ok;
    logic                   emit;
    logic                   sof_out;
    logic                   eof_out;
    logic                   trunc_out;
    logic                   drop_inc;

    // A beat counts only when accepted and addressed to an existing channel;
    // out-of-range tids are silently discarded.
    assign beat_ok = s_axis_tvalid && s_axis_tready && ({1'b0, s_axis_tid} < K_CH_LIMIT);

    // Only the addressed channel is read and rewritten each cycle, which is
    // what lets one channel run back-to-back at full rate.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_state = ST_IDLE;
        cur_cnt   = '0;
        emit      = 1'b0;
        sof_out   = 1'b0;
        eof_out   = 1'b0;
        trunc_out = 1'b0;
        drop_inc  = 1'b0;

        if (beat_ok) begin
            cur_state = state_q[s_axis_tid];
            cur_cnt   = cnt_q[s_axis_tid];
            unique case (cur_state)
                ST_IDLE: begin
                    if (s_axis_tuser) begin
                        emit                 = 1'b1;
                        sof_out              = 1'b1;
                        cnt_d[s_axis_tid]    = K_ONE;
                        state_d[s_axis_tid]  = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    emit = 1'b1;
                    if (cur_cnt == K_LAST_CNT) begin
                        // tlast wins over a coincident start-of-frame; the flag
                        // is then treated as arriving in HOLDOFF (or IDLE).
                        eof_out             = 1'b1;
                        cnt_d[s_axis_tid]   = '0;
                        state_d[s_axis_tid] = (PAR_HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                        if (s_axis_tuser) begin
                            if (PAR_HOLDOFF == 0) begin
                                sof_out             = 1'b1;
                                cnt_d[s_axis_tid]   = K_ONE;
                                state_d[s_axis_tid] = ST_ACTIVE;
                            end else begin
                                drop_inc = 1'b1;
                            end
                        end
                    end else if (s_axis_tuser && (PAR_RETRIGGER != 0)) begin
                        sof_out           = 1'b1;
                        trunc_out         = 1'b1;
                        cnt_d[s_axis_tid] = K_ONE;
                    end else begin
                        drop_inc          = s_axis_tuser;
                        cnt_d[s_axis_tid] = cur_cnt + K_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    drop_inc = s_axis_tuser;
                    if (cur_cnt == K_HOLD_END) begin
                        cnt_d[s_axis_tid]   = '0;
                        state_d[s_axis_tid] = ST_IDLE;
                    end else begin
                        cnt_d[s_axis_tid] = cur_cnt + K_ONE;
                    end
                end
                default: begin
                    cnt_d[s_axis_tid]   = '0;
                    state_d[s_axis_tid] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!i_rst_n) begin
            // NOTE: the per-channel state/counter arrays are plain flops, not
            // RAM, so they are reset explicitly along with everything else.
            for (int c = 0; c < PAR_CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
            end
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            o_trunc       <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= emit;
            m_axis_tuser  <= sof_out;
            m_axis_tlast  <= eof_out;
            o_trunc       <= trunc_out;
            if (emit) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tid   <= s_axis_tid;
            end
            if (drop_inc && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int c = 0; c < PAR_CHANNELS; c++) begin
            o_busy[c] = (state_q[c] != ST_IDLE);
        end
    end

endmodule
